// File: rtl/mips_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// mips_dmem_arbiter
//
// Shares the single-port MIPS data memory between two requesters:
//   port 0 - CPU load/store unit
//   port 1 - DMA / debug loader
// One access is in flight at a time. The memory address, write data and the
// read/write strobes are registered and held for MEM_LATENCY cycles. After
// that the winner gets a one-cycle ack, together with its err flag. A load
// also returns its data on that port's registered rdata.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req0/1, we0/1         request and store(1)/load(0), sampled only in IDLE
//   addr0/1, wdata0/1     byte address and store data, sampled with the request
//   ack0/1, err0/1        one-cycle completion pulse and misalignment flag
//   rdata0/1              last load data returned to that port
//   mem_address, write_data, sig_mem_read, sig_mem_write
//                         registered drive to the data memory
//   read_data             combinational read data from the data memory
//   busy                  state machine is not idle
// -----------------------------------------------------------------------------
module mips_dmem_arbiter #(
    parameter int MEM_LATENCY    = 2,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] mem_address,
    output logic [31:0] write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] read_data,
    output logic        busy
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Latched transaction and arbitration history
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             last_grant_reg, last_grant_next;
    logic             id_reg, id_next;
    logic             we_reg, we_next;
    logic [31:0]      addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic             err_reg, err_next;

    // Registered outputs
    logic [1:0]       ack_reg, ack_next;
    logic [1:0]       err_out_reg, err_out_next;
    logic [1:0][31:0] rdata_reg, rdata_next;
    logic [31:0]      mem_address_reg, mem_address_next;
    logic [31:0]      write_data_reg, write_data_next;
    logic             rd_reg, rd_next;
    logic             wr_reg, wr_next;

    // Arbitration: which port would win if sampled this cycle
    logic        grant_valid;
    logic        grant_id;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_misaligned;

    always_comb begin
        grant_valid = req0 | req1;
        // Port 1 wins when alone, or on a tie in round-robin mode when port 0
        // was the last one served.
        grant_id    = req1 & (~req0 | ((FIXED_PRIORITY == 0) & ~last_grant_reg));
        sel_we      = grant_id ? we1    : we0;
        sel_addr    = grant_id ? addr1  : addr0;
        sel_wdata   = grant_id ? wdata1 : wdata0;
        sel_misaligned = (sel_addr[1:0] != 2'b00);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    // Misaligned requests skip the memory entirely
                    state_next = sel_misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cnt_next         = cnt_reg;
        last_grant_next  = last_grant_reg;
        id_next          = id_reg;
        we_next          = we_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        err_next         = err_reg;
        ack_next         = 2'b00;
        err_out_next     = 2'b00;
        rdata_next       = rdata_reg;
        mem_address_next = '0;
        write_data_next  = '0;
        rd_next          = 1'b0;
        wr_next          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    id_next    = grant_id;
                    we_next    = sel_we;
                    addr_next  = sel_addr;
                    wdata_next = sel_wdata;
                    err_next   = sel_misaligned;
                    cnt_next   = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (!we_reg) begin
                    // Last strobe cycle: memory data is valid on read_data
                    rdata_next[id_reg] = read_data;
                end
            end
            RESP: begin
                ack_next[id_reg]     = 1'b1;
                err_out_next[id_reg] = err_reg;
                last_grant_next      = id_reg;
            end
            default: ;
        endcase

        // Memory drive is registered so it is glitch-free and stable for the
        // whole access window; it follows the state being entered.
        if (state_next == ACCESS) begin
            mem_address_next = addr_next;
            write_data_next  = wdata_next;
            wr_next          = we_next;
            rd_next          = ~we_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg         <= '0;
            last_grant_reg  <= 1'b1;
            id_reg          <= 1'b0;
            we_reg          <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            err_reg         <= 1'b0;
            ack_reg         <= 2'b00;
            err_out_reg     <= 2'b00;
            rdata_reg       <= '0;
            mem_address_reg <= '0;
            write_data_reg  <= '0;
            rd_reg          <= 1'b0;
            wr_reg          <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            last_grant_reg  <= last_grant_next;
            id_reg          <= id_next;
            we_reg          <= we_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            err_reg         <= err_next;
            ack_reg         <= ack_next;
            err_out_reg     <= err_out_next;
            rdata_reg       <= rdata_next;
            mem_address_reg <= mem_address_next;
            write_data_reg  <= write_data_next;
            rd_reg          <= rd_next;
            wr_reg          <= wr_next;
        end
    end

    assign ack0          = ack_reg[0];
    assign ack1          = ack_reg[1];
    assign err0          = err_out_reg[0];
    assign err1          = err_out_reg[1];
    assign rdata0        = rdata_reg[0];
    assign rdata1        = rdata_reg[1];
    assign mem_address   = mem_address_reg;
    assign write_data    = write_data_reg;
    assign sig_mem_read  = rd_reg;
    assign sig_mem_write = wr_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips_dmem_arbiter
//
// Instance A: MEM_LATENCY=2, round-robin. It runs a vector table, a tie
// sequence, reset in mid-access, and a random phase against a
// transaction-level model.
// Instance B: MEM_LATENCY=1, fixed priority. It runs a single load and a
// fixed-priority tie sequence.
// Each instance has a behavioural memory. A store commits only once its write
// strobe has been held for the full latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_dmem_arbiter;

    localparam int ML_A = 2;
    localparam int ML_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_req0, a_req1, a_we0, a_we1;
    logic [31:0] a_addr0, a_addr1, a_wdata0, a_wdata1;
    logic        a_ack0, a_ack1, a_err0, a_err1;
    logic [31:0] a_rdata0, a_rdata1, a_mem_address, a_write_data, a_read_data;
    logic        a_rd, a_wr, a_busy;

    logic        b_req0, b_req1, b_we0, b_we1;
    logic [31:0] b_addr0, b_addr1, b_wdata0, b_wdata1;
    logic        b_ack0, b_ack1, b_err0, b_err1;
    logic [31:0] b_rdata0, b_rdata1, b_mem_address, b_write_data, b_read_data;
    logic        b_rd, b_wr, b_busy;

    mips_dmem_arbiter #(.MEM_LATENCY(ML_A), .FIXED_PRIORITY(0)) dut_a (
        .clk(clk), .reset(reset),
        .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
        .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
        .ack0(a_ack0), .ack1(a_ack1), .err0(a_err0), .err1(a_err1),
        .rdata0(a_rdata0), .rdata1(a_rdata1),
        .mem_address(a_mem_address), .write_data(a_write_data),
        .sig_mem_read(a_rd), .sig_mem_write(a_wr),
        .read_data(a_read_data), .busy(a_busy)
    );

    mips_dmem_arbiter #(.MEM_LATENCY(ML_B), .FIXED_PRIORITY(1)) dut_b (
        .clk(clk), .reset(reset),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
        .ack0(b_ack0), .ack1(b_ack1), .err0(b_err0), .err1(b_err1),
        .rdata0(b_rdata0), .rdata1(b_rdata1),
        .mem_address(b_mem_address), .write_data(b_write_data),
        .sig_mem_read(b_rd), .sig_mem_write(b_wr),
        .read_data(b_read_data), .busy(b_busy)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural memories ----------------
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    int          a_wrun, b_wrun;
    bit          mem_init;

    function automatic logic [31:0] init_word(input int i);
        if (i == 2) return 32'hDEADBEEF;
        return 32'hA000_0000 | 32'(i);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= init_word(i);
                mem_b[i] <= init_word(i);
            end
            a_wrun <= 0;
            b_wrun <= 0;
        end else begin
            if (a_wr) begin
                if (a_wrun + 1 == ML_A) mem_a[a_mem_address[9:2]] <= a_write_data;
                a_wrun <= a_wrun + 1;
            end else begin
                a_wrun <= 0;
            end
            if (b_wr) begin
                if (b_wrun + 1 == ML_B) mem_b[b_mem_address[9:2]] <= b_write_data;
                b_wrun <= b_wrun + 1;
            end else begin
                b_wrun <= 0;
            end
        end
    end

    assign a_read_data = mem_a[a_mem_address[9:2]];
    assign b_read_data = mem_b[b_mem_address[9:2]];

    // Invariants on every cycle outside reset
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check1("a_two_acks", a_ack0 & a_ack1, 1'b0);
            check1("a_two_strobes", a_rd & a_wr, 1'b0);
            check1("b_two_acks", b_ack0 & b_ack1, 1'b0);
            check1("b_two_strobes", b_rd & b_wr, 1'b0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic clear_inputs();
        a_req0 = 0; a_req1 = 0; a_we0 = 0; a_we1 = 0;
        a_addr0 = '0; a_addr1 = '0; a_wdata0 = '0; a_wdata1 = '0;
        b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
        b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
        int          exp_strobes;
    } vec_t;

    vec_t vecs [10];

    // One isolated transaction on instance A
    task automatic a_txn(input vec_t v, input int idx);
        int   lat, strobes, t0;
        bit   got, drive_ok, pulse_ok;
        logic err_seen;
        logic [31:0] rdata_seen;
        lat = 0; strobes = 0; got = 0; drive_ok = 1; err_seen = 0; rdata_seen = '0;
        @(negedge clk);
        if (v.port) begin
            a_req1 = 1; a_we1 = v.we; a_addr1 = v.addr; a_wdata1 = v.wdata;
        end else begin
            a_req0 = 1; a_we0 = v.we; a_addr0 = v.addr; a_wdata0 = v.wdata;
        end
        t0 = cyc + 1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (a_rd | a_wr) begin
                strobes++;
                if (a_mem_address !== v.addr || a_wr !== v.we ||
                    (v.we && a_write_data !== v.wdata)) drive_ok = 0;
            end
            if (v.port ? a_ack1 : a_ack0) begin
                got        = 1;
                lat        = cyc - t0;
                err_seen   = v.port ? a_err1 : a_err0;
                rdata_seen = v.port ? a_rdata1 : a_rdata0;
            end
        end
        a_req0 = 0; a_req1 = 0;
        $display("vec %0d port=%0d we=%0d addr=%h lat=%0d strobes=%0d err=%0d rdata=%h",
                 idx, v.port, v.we, v.addr, lat, strobes, err_seen, rdata_seen);
        check1("vec_ack_seen", got, 1'b1);
        check32("vec_latency", 32'(lat), 32'(v.exp_lat));
        check32("vec_strobe_cycles", 32'(strobes), 32'(v.exp_strobes));
        check1("vec_mem_drive", drive_ok, 1'b1);
        check1("vec_err", err_seen, v.exp_err);
        check32("vec_rdata", rdata_seen, v.exp_rdata);
        @(negedge clk);
        pulse_ok = !(a_ack0 | a_ack1);
        check1("vec_ack_one_cycle", pulse_ok, 1'b1);
    endtask

    // ---------------- random-phase model state ----------------
    bit          pend [2];
    bit          pwe [2];
    logic [31:0] paddr [2];
    logic [31:0] pwdata [2];
    logic [31:0] shadow [0:255];
    logic [31:0] exp_rd [2];
    bit          act, act_port, act_we, act_mis;
    int          act_start, act_ack;
    logic [31:0] act_addr;

    initial begin
        int   order [4];
        int   ack_cyc [4];
        int   n, lat, strobes, t0, c;
        bit   got, ack_leak, w, in_win;
        logic e_ack0, e_ack1;
        logic [31:0] e_addr;
        int   mem_bad;

        reset = 1'b1;
        mem_init = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        do_reset();

        // Reset state
        check1("rst_ack0", a_ack0, 1'b0);
        check1("rst_ack1", a_ack1, 1'b0);
        check1("rst_err0", a_err0, 1'b0);
        check1("rst_err1", a_err1, 1'b0);
        check32("rst_rdata0", a_rdata0, 32'h0);
        check32("rst_rdata1", a_rdata1, 32'h0);
        check32("rst_mem_address", a_mem_address, 32'h0);
        check32("rst_write_data", a_write_data, 32'h0);
        check1("rst_rd", a_rd, 1'b0);
        check1("rst_wr", a_wr, 1'b0);
        check1("rst_busy", a_busy, 1'b0);
        check1("rst_b_busy", b_busy, 1'b0);

        // ---------- vector table (instance A, MEM_LATENCY=2) ----------
        vecs[0] = '{1'b0, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 3, 2};
        vecs[1] = '{1'b1, 1'b1, 32'h10, 32'h12345678, 32'h00000000, 1'b0, 3, 2};
        vecs[2] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'h12345678, 1'b0, 3, 2};
        vecs[3] = '{1'b0, 1'b0, 32'h06, 32'h0,        32'h12345678, 1'b1, 1, 0};
        vecs[4] = '{1'b1, 1'b0, 32'h0C, 32'h0,        32'hA0000003, 1'b0, 3, 2};
        vecs[5] = '{1'b1, 1'b1, 32'h13, 32'hFFFF0000, 32'hA0000003, 1'b1, 1, 0};
        vecs[6] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'h12345678, 1'b0, 3, 2};
        vecs[7] = '{1'b1, 1'b1, 32'h04, 32'hCAFEF00D, 32'hA0000003, 1'b0, 3, 2};
        vecs[8] = '{1'b1, 1'b0, 32'h04, 32'h0,        32'hCAFEF00D, 1'b0, 3, 2};
        vecs[9] = '{1'b0, 1'b0, 32'h01, 32'h0,        32'h12345678, 1'b1, 1, 0};
        for (int i = 0; i < 10; i++) a_txn(vecs[i], i);

        // ---------- round-robin tie on A from reset ----------
        do_reset();
        @(negedge clk);
        a_req0 = 1; a_we0 = 0; a_addr0 = 32'h0;
        a_req1 = 1; a_we1 = 0; a_addr1 = 32'h8;
        n = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (a_ack0 | a_ack1) begin
                order[n] = a_ack1 ? 1 : 0;
                ack_cyc[n] = cyc;
                $display("rr ack %0d port=%0d cyc=%0d", n, order[n], cyc);
                n++;
            end
        end
        a_req0 = 0; a_req1 = 0;
        check32("rr_ack_count", 32'(n), 32'd4);
        if (n == 4) begin
            check32("rr_order0", 32'(order[0]), 32'd0);
            check32("rr_order1", 32'(order[1]), 32'd1);
            check32("rr_order2", 32'(order[2]), 32'd0);
            check32("rr_order3", 32'(order[3]), 32'd1);
            check32("rr_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'(ML_A + 2));
        end
        check32("rr_rdata0", a_rdata0, 32'hA0000000);
        check32("rr_rdata1", a_rdata1, 32'hDEADBEEF);

        // ---------- reset in the first ACCESS cycle of a port-1 store ----------
        repeat (2) @(negedge clk);
        a_req1 = 1; a_we1 = 1; a_addr1 = 32'h20; a_wdata1 = 32'h55AA55AA;
        @(negedge clk);
        check1("rstmid_wr_first", a_wr, 1'b1);
        reset = 1'b1;
        a_req1 = 0;
        @(negedge clk);
        check1("rstmid_wr", a_wr, 1'b0);
        check1("rstmid_rd", a_rd, 1'b0);
        check1("rstmid_busy", a_busy, 1'b0);
        check1("rstmid_ack1", a_ack1, 1'b0);
        reset = 1'b0;
        ack_leak = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_ack0 | a_ack1 | a_busy) ack_leak = 1;
        end
        check1("rstmid_no_ack", ack_leak, 1'b0);
        check32("rstmid_mem_word", mem_a[8], 32'hA0000008);

        // ---------- instance B: MEM_LATENCY=1, fixed priority ----------
        @(negedge clk);
        b_req0 = 1; b_we0 = 0; b_addr0 = 32'h8;
        t0 = cyc + 1; got = 0; lat = 0; strobes = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (b_rd) strobes++;
            if (b_ack0) begin
                got = 1;
                lat = cyc - t0;
            end
        end
        b_req0 = 0;
        $display("b load port=0 addr=%h lat=%0d strobes=%0d rdata=%h", 32'h8, lat, strobes, b_rdata0);
        check1("b_ld_ack_seen", got, 1'b1);
        check32("b_ld_latency", 32'(lat), 32'd2);
        check32("b_ld_strobes", 32'(strobes), 32'd1);
        check32("b_ld_rdata", b_rdata0, 32'hDEADBEEF);
        check1("b_ld_err", b_err0, 1'b0);

        @(negedge clk);
        b_req0 = 1; b_we0 = 0; b_addr0 = 32'h0;
        b_req1 = 1; b_we1 = 0; b_addr1 = 32'h8;
        n = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            @(negedge clk);
            if (b_ack0 | b_ack1) begin
                order[n] = b_ack1 ? 1 : 0;
                ack_cyc[n] = cyc;
                $display("fp ack %0d port=%0d cyc=%0d", n, order[n], cyc);
                n++;
                if (n == 3) b_req0 = 0;
            end
        end
        b_req0 = 0; b_req1 = 0;
        check32("fp_ack_count", 32'(n), 32'd4);
        if (n == 4) begin
            check32("fp_order0", 32'(order[0]), 32'd0);
            check32("fp_order1", 32'(order[1]), 32'd0);
            check32("fp_order2", 32'(order[2]), 32'd0);
            check32("fp_order3", 32'(order[3]), 32'd1);
            check32("fp_spacing", 32'(ack_cyc[1] - ack_cyc[0]), 32'(ML_B + 2));
        end
        check32("fp_rdata0", b_rdata0, 32'hA0000000);
        check32("fp_rdata1", b_rdata1, 32'hDEADBEEF);

        // ---------- random phase on A against a transaction model ----------
        do_reset();
        for (int i = 0; i < 256; i++) shadow[i] = mem_a[i];
        pend[0] = 0; pend[1] = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        act = 0; act_port = 0; act_we = 0; act_mis = 0;
        act_start = 0; act_ack = 0; act_addr = '0;
        w = 1;  // port served last; port 0 wins the first tie
        for (int step = 0; step < 1500; step++) begin
            @(negedge clk);
            c = cyc;
            e_ack0 = act && (c == act_ack) && !act_port;
            e_ack1 = act && (c == act_ack) && act_port;
            in_win = act && !act_mis && (c >= act_start) && (c <= act_start + ML_A - 1);
            e_addr = in_win ? act_addr : 32'h0;
            check1("rnd_ack0", a_ack0, e_ack0);
            check1("rnd_ack1", a_ack1, e_ack1);
            check1("rnd_rd", a_rd, in_win & !act_we);
            check1("rnd_wr", a_wr, in_win & act_we);
            check32("rnd_mem_address", a_mem_address, e_addr);
            check1("rnd_busy", a_busy, act && (c >= act_start) && (c < act_ack));
            if (act && c == act_ack) begin
                check1("rnd_err", act_port ? a_err1 : a_err0, act_mis);
                check32("rnd_rdata0", a_rdata0, exp_rd[0]);
                check32("rnd_rdata1", a_rdata1, exp_rd[1]);
                $display("rnd txn port=%0d we=%0d addr=%h err=%0d rdata=%h cyc=%0d",
                         act_port, act_we, act_addr, act_mis,
                         act_port ? a_rdata1 : a_rdata0, c);
                pend[act_port] = 0;
                act = 0;
            end
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 3) == 0) begin
                    pend[p]   = 1;
                    pwe[p]    = 1'($urandom_range(0, 1));
                    paddr[p]  = 32'($urandom_range(0, 63)) << 2;
                    if ($urandom_range(0, 7) == 0) paddr[p][1:0] = 2'($urandom_range(1, 3));
                    pwdata[p] = $urandom;
                end
            end
            a_req0 = pend[0]; a_we0 = pwe[0]; a_addr0 = paddr[0]; a_wdata0 = pwdata[0];
            a_req1 = pend[1]; a_we1 = pwe[1]; a_addr1 = paddr[1]; a_wdata1 = pwdata[1];
            // Decision the arbiter should make at the next edge
            if (!act && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) w = !w;
                else                    w = pend[1];
                act       = 1;
                act_port  = w;
                act_we    = pwe[w];
                act_addr  = paddr[w];
                act_mis   = (paddr[w][1:0] != 2'b00);
                act_start = c + 1;
                act_ack   = act_start + (act_mis ? 1 : ML_A + 1);
                if (!act_mis) begin
                    if (act_we) shadow[paddr[w][9:2]] = pwdata[w];
                    else        exp_rd[w] = shadow[paddr[w][9:2]];
                end
            end
        end
        clear_inputs();
        repeat (8) @(negedge clk);
        mem_bad = 0;
        for (int i = 0; i < 256; i++) if (mem_a[i] !== shadow[i]) mem_bad++;
        check32("rnd_final_memory_mismatches", 32'(mem_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
